// File: rtl/mem_if.sv
// Data-memory request/acknowledge bus between the MEM-stage access unit
// (master) and the data memory (slave).
interface mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage access controller: passes non-memory instructions straight to MEM/WB
// and runs loads/stores over a variable-latency req/ack bus, stalling upstream.
module mem_access_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  WB_in,
    input  logic [1:0]  M_in,
    input  logic [31:0] ALUresult_in,
    input  logic [31:0] write_mem_data_in,
    input  logic [4:0]  write_register_in,
    mem_if.master       mem,
    output logic        stall_out,
    output logic [1:0]  WB_out,
    output logic [31:0] read_data_out,
    output logic [31:0] ALUresult_out,
    output logic [4:0]  write_register_out,
    output logic        err_out
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       wb_hold;
    logic [4:0]       reg_hold;

    logic is_mem;
    logic bad_access;
    logic pass;
    logic accept;
    logic reject;
    logic complete;
    logic abort;

    // Decode of the EX/MEM instruction and of the outstanding transaction
    always_comb begin
        is_mem     = (M_in != 2'b00);
        bad_access = is_mem && ((M_in == 2'b11) || (ALUresult_in[1:0] != 2'b00));
        pass       = (state == IDLE) && !is_mem;
        accept     = (state == IDLE) && is_mem && !bad_access;
        reject     = (state == IDLE) && bad_access;
        complete   = (state == BUSY) && mem.mem_ack;
        abort      = (state == BUSY) && !mem.mem_ack && (cnt == CNT_LAST);
    end

    assign stall_out = (state == BUSY);

    // Control: state and timeout counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            if (accept) begin
                state <= BUSY;
                cnt   <= '0;
            end else if (complete || abort) begin
                state <= IDLE;
            end else if (state == BUSY) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Request stage: bus fields are captured once at accept so they stay
    // stable for the whole time mem_req is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            wb_hold       <= '0;
            reg_hold      <= '0;
        end else begin
            if (accept) begin
                mem.mem_req   <= 1'b1;
                mem.mem_we    <= M_in[0];
                mem.mem_addr  <= ALUresult_in;
                mem.mem_wdata <= write_mem_data_in;
                wb_hold       <= WB_in;
                reg_hold      <= write_register_in;
            end else if (complete || abort) begin
                mem.mem_req <= 1'b0;
            end
        end
    end

    // Result stage toward MEM/WB: WB_out is non-zero only on a completing cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WB_out             <= '0;
            read_data_out      <= '0;
            ALUresult_out      <= '0;
            write_register_out <= '0;
            err_out            <= 1'b0;
        end else begin
            err_out <= reject || abort;
            if (pass) begin
                WB_out             <= WB_in;
                read_data_out      <= '0;
                ALUresult_out      <= ALUresult_in;
                write_register_out <= write_register_in;
            end else if (complete) begin
                WB_out             <= wb_hold;
                read_data_out      <= mem.mem_we ? 32'h0 : mem.mem_rdata;
                ALUresult_out      <= mem.mem_addr;
                write_register_out <= reg_hold;
            end else begin
                WB_out <= '0;
            end
        end
    end

endmodule
